// File: rtl/striping_2lanes_if.sv
// Word stream into the two-lane striper and the lane/debug outputs it produces.
interface striping_2lanes_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
);
   logic              valid_in;
   logic [DATA_W-1:0] data_in;
   logic              valid_lane0;
   logic [DATA_W-1:0] data_lane0;
   logic              valid_lane1;
   logic [DATA_W-1:0] data_lane1;
   logic              lane_sel;
   logic              active_out;
   logic [CNT_W-1:0]  words_lane0;
   logic [CNT_W-1:0]  words_lane1;

   modport master (
      output valid_in, data_in,
      input  valid_lane0, data_lane0, valid_lane1, data_lane1,
      input  lane_sel, active_out, words_lane0, words_lane1
   );

   modport slave (
      input  valid_in, data_in,
      output valid_lane0, data_lane0, valid_lane1, data_lane1,
      output lane_sel, active_out, words_lane0, words_lane1
   );
endinterface

// File: rtl/striping_2lanes.sv
// Alternates valid words across two lanes; an idle gap of IDLE_LIMIT cycles
// drops back to IDLE and realigns the lane pointer to lane0.
//
//  state     | meaning
//  ST_IDLE   | no recent traffic, lane pointer aligned to lane0
//  ST_ACTIVE | streaming; idle counter tracks the current invalid gap
module striping_2lanes #(
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 8,
   parameter int IDLE_LIMIT = 4
) (
   input logic               clk_2f,
   input logic               reset,
   striping_2lanes_if.slave  bus
);
   localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t              state_q,    state_d;
   logic                lane_sel_q, lane_sel_d;
   logic                valid0_q,   valid0_d;
   logic                valid1_q,   valid1_d;
   logic [DATA_W-1:0]   data0_q,    data0_d;
   logic [DATA_W-1:0]   data1_q,    data1_d;
   logic [CNT_W-1:0]    words0_q,   words0_d;
   logic [CNT_W-1:0]    words1_q,   words1_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

   always_comb begin
      state_d    = state_q;
      lane_sel_d = lane_sel_q;
      valid0_d   = 1'b0;
      valid1_d   = 1'b0;
      data0_d    = data0_q;
      data1_d    = data1_q;
      words0_d   = words0_q;
      words1_d   = words1_q;
      idle_cnt_d = idle_cnt_q;

      if (bus.valid_in) begin
         if (!lane_sel_q) begin
            valid0_d = 1'b1;
            data0_d  = bus.data_in;
            words0_d = words0_q + 1'b1;
         end else begin
            valid1_d = 1'b1;
            data1_d  = bus.data_in;
            words1_d = words1_q + 1'b1;
         end
         lane_sel_d = ~lane_sel_q;
         idle_cnt_d = '0;
         state_d    = ST_ACTIVE;
      end else if (state_q == ST_ACTIVE) begin
         // This invalid cycle is the IDLE_LIMIT-th in a row.
         if (idle_cnt_q == IDLE_LAST) begin
            state_d    = ST_IDLE;
            lane_sel_d = 1'b0;
            idle_cnt_d = '0;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lane_sel_q <= 1'b0;
         valid0_q   <= 1'b0;
         valid1_q   <= 1'b0;
         data0_q    <= '0;
         data1_q    <= '0;
         words0_q   <= '0;
         words1_q   <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lane_sel_q <= lane_sel_d;
         valid0_q   <= valid0_d;
         valid1_q   <= valid1_d;
         data0_q    <= data0_d;
         data1_q    <= data1_d;
         words0_q   <= words0_d;
         words1_q   <= words1_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign bus.valid_lane0 = valid0_q;
   assign bus.data_lane0  = data0_q;
   assign bus.valid_lane1 = valid1_q;
   assign bus.data_lane1  = data1_q;
   assign bus.lane_sel    = lane_sel_q;
   assign bus.active_out  = (state_q == ST_ACTIVE);
   assign bus.words_lane0 = words0_q;
   assign bus.words_lane1 = words1_q;
endmodule

// File: tb/tb_striping_2lanes.sv
// Directed bench for striping_2lanes: routing, gaps, idle realignment,
// reset mid-stream and counter wrap.
module tb_striping_2lanes;
   logic clk_2f = 1'b0;
   logic reset  = 1'b1;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   always #5 clk_2f = ~clk_2f;

   striping_2lanes_if #(.DATA_W(32), .CNT_W(8)) sif ();

   striping_2lanes #(.DATA_W(32), .CNT_W(8), .IDLE_LIMIT(4)) dut (
      .clk_2f (clk_2f),
      .reset  (reset),
      .bus    (sif.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d);
      sif.valid_in = v;
      sif.data_in  = d;
      @(posedge clk_2f);
      #1;
   endtask

   task automatic expect_all(input string tag,
                             input logic v0, input logic [31:0] d0,
                             input logic v1, input logic [31:0] d1,
                             input logic ls, input logic act,
                             input logic [7:0] w0, input logic [7:0] w1);
      check_eq({tag, ".valid_lane0"}, 32'(sif.valid_lane0), 32'(v0));
      check_eq({tag, ".data_lane0"},  sif.data_lane0,       d0);
      check_eq({tag, ".valid_lane1"}, 32'(sif.valid_lane1), 32'(v1));
      check_eq({tag, ".data_lane1"},  sif.data_lane1,       d1);
      check_eq({tag, ".lane_sel"},    32'(sif.lane_sel),    32'(ls));
      check_eq({tag, ".active_out"},  32'(sif.active_out),  32'(act));
      check_eq({tag, ".words_lane0"}, 32'(sif.words_lane0), 32'(w0));
      check_eq({tag, ".words_lane1"}, 32'(sif.words_lane1), 32'(w1));
   endtask

   initial begin
      sif.valid_in = 1'b0;
      sif.data_in  = '0;

      // Reset with valid words present: they must be dropped.
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 32'h5555_0000 + i);
      expect_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Back-to-back
      step(1, 32'hA000_0001); expect_all("a1", 1, 32'hA000_0001, 0, 0,            1, 1, 1, 0);
      step(1, 32'hA000_0002); expect_all("a2", 0, 32'hA000_0001, 1, 32'hA000_0002, 0, 1, 1, 1);
      step(1, 32'hA000_0003); expect_all("a3", 1, 32'hA000_0003, 0, 32'hA000_0002, 1, 1, 2, 1);
      step(1, 32'hA000_0004); expect_all("a4", 0, 32'hA000_0003, 1, 32'hA000_0004, 0, 1, 2, 2);

      // Single-cycle gaps
      step(0, 32'h0);  expect_all("g0", 0, 32'hA000_0003, 0, 32'hA000_0004, 0, 1, 2, 2);
      step(1, 32'hB1); expect_all("b1", 1, 32'hB1, 0, 32'hA000_0004, 1, 1, 3, 2);
      step(0, 32'h0);  expect_all("g1", 0, 32'hB1, 0, 32'hA000_0004, 1, 1, 3, 2);
      step(1, 32'hB2); expect_all("b2", 0, 32'hB1, 1, 32'hB2, 0, 1, 3, 3);
      step(0, 32'h0);  expect_all("g2", 0, 32'hB1, 0, 32'hB2, 0, 1, 3, 3);
      step(1, 32'hB3); expect_all("b3", 1, 32'hB3, 0, 32'hB2, 1, 1, 4, 3);

      // Idle limit with lane_sel=1: realign on the 4th invalid edge
      for (int i = 0; i < 3; i++) begin
         step(0, 32'h0); expect_all("gap_b", 0, 32'hB3, 0, 32'hB2, 1, 1, 4, 3);
      end
      step(0, 32'h0); expect_all("realign_b", 0, 32'hB3, 0, 32'hB2, 0, 0, 4, 3);

      step(1, 32'hC1); expect_all("c1", 1, 32'hC1, 0, 32'hB2, 1, 1, 5, 3);
      for (int i = 0; i < 3; i++) begin
         step(0, 32'h0); expect_all("gap_c", 0, 32'hC1, 0, 32'hB2, 1, 1, 5, 3);
      end
      step(0, 32'h0);  expect_all("realign_c", 0, 32'hC1, 0, 32'hB2, 0, 0, 5, 3);
      step(1, 32'hC2); expect_all("c2", 1, 32'hC2, 0, 32'hB2, 1, 1, 6, 3);

      // Word arriving on what would be the limit cycle keeps ACTIVE
      step(1, 32'h11); expect_all("d11", 0, 32'hC2, 1, 32'h11, 0, 1, 6, 4);
      step(1, 32'h12); expect_all("d12", 1, 32'h12, 0, 32'h11, 1, 1, 7, 4);
      for (int i = 0; i < 3; i++) begin
         step(0, 32'h0); expect_all("gap_d", 0, 32'h12, 0, 32'h11, 1, 1, 7, 4);
      end
      step(1, 32'h13); expect_all("d13", 0, 32'h12, 1, 32'h13, 0, 1, 7, 5);
      for (int i = 0; i < 3; i++) begin
         step(0, 32'h0); expect_all("restart", 0, 32'h12, 0, 32'h13, 0, 1, 7, 5);
      end
      step(0, 32'h0); expect_all("drop_ls0", 0, 32'h12, 0, 32'h13, 0, 0, 7, 5);

      // Reset mid-stream with a valid word
      for (int i = 1; i <= 5; i++) step(1, 32'hF0 + i);
      expect_all("f5", 1, 32'hF5, 0, 32'hF4, 1, 1, 10, 7);
      reset = 1'b1;
      step(1, 32'hDEAD); expect_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step(1, 32'h77); expect_all("post_rst", 1, 32'h77, 0, 0, 1, 1, 1, 0);

      // 512 back-to-back words from a clean reset: each counter wraps once
      reset = 1'b1;
      step(0, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 512; i++) begin
         logic [31:0] w;
         w = 32'h9000_0000 + i;
         step(1, w);
         if (i % 2 == 0) begin
            check_eq("wrap.v0", 32'(sif.valid_lane0), 32'd1);
            check_eq("wrap.d0", sif.data_lane0, w);
         end else begin
            check_eq("wrap.v1", 32'(sif.valid_lane1), 32'd1);
            check_eq("wrap.d1", sif.data_lane1, w);
         end
         check_eq("wrap.w0", 32'(sif.words_lane0), ((i + 2) / 2) % 256);
         check_eq("wrap.w1", 32'(sif.words_lane1), ((i + 1) / 2) % 256);
      end
      check_eq("wrap.end_w0", 32'(sif.words_lane0), 32'd0);
      check_eq("wrap.end_w1", 32'(sif.words_lane1), 32'd0);
      check_eq("wrap.end_ls", 32'(sif.lane_sel), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
